// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin shares one sll/sra shifter among NUM_REQ requesters into a single result slot
module shift_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ-1:0]     req_op,
  input  logic [32*NUM_REQ-1:0]  req_data,
  input  logic [5*NUM_REQ-1:0]   req_shamt,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [31:0]            res_data,
  output logic [1:0]             res_id
);
  logic        res_valid_q, res_valid_d;
  logic [31:0] res_data_q, res_data_d;
  logic [1:0]  res_id_q, res_id_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic        slot_free, gnt_found, hi_found, accept, sel_op;
  logic [1:0]  gnt_idx, hi_idx, lo_idx;
  logic [31:0] sel_data, sll_val, sra_val;
  logic [4:0]  sel_shamt;
  always_comb begin
    slot_free = !res_valid_q || res_ready;
    gnt_found = |req_valid;
    hi_found  = 1'b0;
    hi_idx    = '0;
    lo_idx    = '0;
    // descending scan leaves the lowest match; hi_* only considers indices at/after the pointer
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) lo_idx = 2'(i);
      if (req_valid[i] && 2'(i) >= rr_ptr_q) begin
        hi_found = 1'b1;
        hi_idx   = 2'(i);
      end
    end
    gnt_idx   = hi_found ? hi_idx : lo_idx;
    req_ready = '0;
    sel_data  = '0;
    sel_shamt = '0;
    sel_op    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = !reset && slot_free && gnt_found && gnt_idx == 2'(i);
      if (gnt_idx == 2'(i)) begin
        sel_data  = req_data[32*i +: 32];
        sel_shamt = req_shamt[5*i +: 5];
        sel_op    = req_op[i];
      end
    end
    accept      = |(req_valid & req_ready);
    sll_val     = sel_data << sel_shamt;
    sra_val     = $signed(sel_data) >>> sel_shamt;
    res_valid_d = accept ? 1'b1 : (res_ready ? 1'b0 : res_valid_q);
    res_data_d  = accept ? (sel_op ? sra_val : sll_val) : res_data_q;
    res_id_d    = accept ? gnt_idx : res_id_q;
    rr_ptr_d    = accept ? (gnt_idx == 2'(NUM_REQ - 1) ? 2'd0 : gnt_idx + 2'd1) : rr_ptr_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
endmodule
